adc_spi_responder: RTL
======================

Name: adc_spi_responder

Overview:
- Synthesizable SPI responder that emulates the 8-channel, 12-bit serial ADC the existing driver talks to, for FPGA loopback and bench self-test.
- Accepts the driver's CS/SCLK/control-in lines and returns 16-bit frames: 4 leading zeros, then the 12-bit sample MSB-first.
- The samples come from an internal per-channel register file, written by local logic.
- Frame N returns the channel addressed during frame N-1, as the real device does.

Parameters:
- NUM_CH, 8, number of emulated channels; the address field is 3 bits.
- DATA_W, 12, sample width.
- SYNC_STAGES, 2, synchronizer depth on Spi_cs_n, Spi_sclk and Spi_din.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Rst  in  1  synchronous reset, active-high.
- Spi_cs_n  in  1  chip select from the ADC driver, active-low.
- Spi_sclk  in  1  serial clock from the driver; its frequency must be ≤ Clk/8.
- Spi_din  in  1  control word from the driver, sampled on SCLK rising edges.
- Spi_dout  out  1  serial data to the driver; changes after SCLK falling edges.
- Ch_wr_en  in  1  write strobe for the sample register file.
- Ch_wr_addr  in  3  channel to write.
- Ch_wr_data  in  DATA_W  sample value.
- Frame_done  out  1  one-Clk pulse when a complete 16-bit frame finishes.
- Frame_err  out  1  one-Clk pulse when CS deasserts mid-frame.
- Cur_addr  out  3  channel address that takes effect in the next frame.

Behaviour:
- Reset values:
  - Spi_dout=0, Frame_done=0, Frame_err=0, Cur_addr=0.
  - Register file all zeros.
  - State IDLE, bit counter 0.
- Input conditioning:
  - Spi_cs_n, Spi_sclk and Spi_din pass through SYNC_STAGES flops.
  - Edge detection compares the last two synchronized samples.
  - All SPI events are therefore seen 2-3 Clk after the pin toggles.
- IDLE:
  - Spi_dout=0.
  - CS falling edge → load shift_reg = {4'b0, regfile[Cur_addr]}, Spi_dout = shift_reg[15] (0), bit_cnt=0, go to SHIFT.
- SHIFT, each SCLK rising edge:
  - bit_cnt increments.
  - Spi_din is captured at rising edges 3, 4 and 5 (1-indexed) into next_addr[2], [1] and [0] respectively.
  - All other DIN bits are ignored.
- SHIFT, each SCLK falling edge:
  - shift_reg shifts left, zero-filled; Spi_dout = new shift_reg[15].
- SHIFT, 16th rising edge:
  - Cur_addr <= next_addr; Frame_done pulses; bit_cnt wraps to 0.
- Continuous mode: if CS stays low, the 16th falling edge reloads shift_reg = {4'b0, regfile[new Cur_addr]} instead of shifting, and a new frame begins.
- CS rising edge:
  - Return to IDLE, Spi_dout=0.
  - If bit_cnt≠0 the frame was partial: Frame_err pulses and Cur_addr is NOT updated.
- CS rising edge coinciding with the 16th rising edge: the frame counts as complete. Frame_done pulses, no Frame_err.
- Register file:
  - A write lands on the next Clk.
  - A sample is snapshotted at load time; a write in the same Clk as the load returns the OLD value, and the new value appears in the following frame.
  - Writes during SHIFT never alter the frame in flight.
- SCLK edges while in IDLE (CS high) are ignored.
- Reset asserted mid-frame aborts immediately to the reset values, with no Frame_err.
- Spi_dout is a plain driven output; no tristate.

Test Plan:
- Reset, then regfile[0]=12'hA5C and regfile[3]=12'h123. Frame 1 with DIN addr=3 → DOUT bits 0000_1010_0101_1100, Frame_done=1 pulse, Cur_addr=3. Frame 2 with addr=0 → DOUT 0x0123.
- Continuous mode: CS held low for 32 SCLK, addresses 5 then 6, regfile[5]=12'hFFF → the second 16 bits read 0x0FFF, two Frame_done pulses, Cur_addr=6 at the end.
- Abort: CS raised after 9 rising edges with addr=7 → Frame_err=1 pulse, no Frame_done, Cur_addr unchanged, Spi_dout=0 within 3 Clk.
- Write race: Ch_wr_en to channel 2 (12'h800) in the same Clk as the CS fall with Cur_addr=2, old value 12'h001 → frame returns 0x0001, next frame returns 0x0800.
- Reset mid-frame after 6 edges → all outputs 0, regfile cleared. The next complete frame returns 0x0000 from channel 0.
- SCLK at Clk/8 (6.25 MHz) and at 1.92 MHz with random samples/addresses over 200 frames → every returned word equals {4'b0, regfile[previous addr]}.

Source files
------------

// File: rtl/adc_spi_responder_if.sv
// adc_spi_responder_if
// Bundles the SPI pins and the sample-write port of the ADC emulator.
//   master : the side that drives the SPI bus and writes samples (driver/bench)
//   slave  : the responder itself
// Signals:
//   Spi_cs_n, Spi_sclk, Spi_din    SPI lines from the driver
//   Spi_dout                       serial sample data back to the driver
//   Ch_wr_en, Ch_wr_addr, Ch_wr_data  sample register file write port
//   Frame_done, Frame_err          one-Clk status pulses
//   Cur_addr                       channel that the next frame will return
interface adc_spi_responder_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 12
);
    logic              Spi_cs_n;
    logic              Spi_sclk;
    logic              Spi_din;
    logic              Spi_dout;
    logic              Ch_wr_en;
    logic [ADDR_W-1:0] Ch_wr_addr;
    logic [DATA_W-1:0] Ch_wr_data;
    logic              Frame_done;
    logic              Frame_err;
    logic [ADDR_W-1:0] Cur_addr;

    modport master (
        output Spi_cs_n, Spi_sclk, Spi_din, Ch_wr_en, Ch_wr_addr, Ch_wr_data,
        input  Spi_dout, Frame_done, Frame_err, Cur_addr
    );

    modport slave (
        input  Spi_cs_n, Spi_sclk, Spi_din, Ch_wr_en, Ch_wr_addr, Ch_wr_data,
        output Spi_dout, Frame_done, Frame_err, Cur_addr
    );
endinterface

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// Emulates an 8-channel 12-bit serial ADC on SPI for loopback/self-test.
// Each 16-bit frame returns 4 zeros then the 12-bit sample MSB-first; the
// channel returned is the one addressed (DIN bits 3..5) in the previous frame.
// Ports:
//   Clk  system clock (SPI lines are oversampled, SCLK <= Clk/8)
//   Rst  synchronous active-high reset
//   bus  adc_spi_responder_if.slave: SPI pins, sample write port, status
module adc_spi_responder #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    adc_spi_responder_if.slave   bus
);
    localparam int ADDR_W  = $clog2(NUM_CH);
    localparam int FRAME_W = 16;
    localparam int PAD_W   = FRAME_W - DATA_W;

    typedef enum logic {IDLE, SHIFT} state_t;

    // ---------------- input synchronizers: {cs_n, sclk, din} ----------------
    // Requires SYNC_STAGES >= 2. Reset value models an idle bus (CS high).
    logic [2:0] sync_reg [SYNC_STAGES];
    logic [1:0] prev_reg;   // previous synchronized {cs_n, sclk}

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= 3'b100;
            prev_reg <= 2'b10;
        end else begin
            sync_reg[0] <= {bus.Spi_cs_n, bus.Spi_sclk, bus.Spi_din};
            for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
            prev_reg <= sync_reg[SYNC_STAGES-1][2:1];
        end
    end

    logic cs_s, sclk_s, din_s;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    assign cs_s      = sync_reg[SYNC_STAGES-1][2];
    assign sclk_s    = sync_reg[SYNC_STAGES-1][1];
    assign din_s     = sync_reg[SYNC_STAGES-1][0];
    assign cs_fall   =  prev_reg[1] & ~cs_s;
    assign cs_rise   = ~prev_reg[1] &  cs_s;
    assign sclk_rise = ~prev_reg[0] &  sclk_s;
    assign sclk_fall =  prev_reg[0] & ~sclk_s;

    // ---------------- sample register file ----------------
    logic [DATA_W-1:0] regfile_reg [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_regfile
            always_ff @(posedge Clk) begin
                if (Rst)
                    regfile_reg[gi] <= '0;
                else if (bus.Ch_wr_en && bus.Ch_wr_addr == ADDR_W'(gi))
                    regfile_reg[gi] <= bus.Ch_wr_data;
            end
        end
    endgenerate

    // ---------------- frame engine ----------------
    state_t             state_reg,     state_next;
    logic [FRAME_W-1:0] shift_reg,     shift_next;
    logic [3:0]         bit_cnt_reg,   bit_cnt_next;
    logic [ADDR_W-1:0]  next_addr_reg, next_addr_next;
    logic [ADDR_W-1:0]  cur_addr_reg,  cur_addr_next;
    logic               wrap_reg,      wrap_next;   // 16th rise seen, reload on next fall
    logic               done_reg,      done_next;
    logic               err_reg,       err_next;

    logic [FRAME_W-1:0] load_word;
    assign load_word = {{PAD_W{1'b0}}, regfile_reg[cur_addr_reg]};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            next_addr_reg <= '0;
            cur_addr_reg  <= '0;
            wrap_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            next_addr_reg <= next_addr_next;
            cur_addr_reg  <= cur_addr_next;
            wrap_reg      <= wrap_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt_reg;
        next_addr_next = next_addr_reg;
        cur_addr_next  = cur_addr_reg;
        wrap_next      = wrap_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                shift_next = '0;
                if (cs_fall) begin
                    // Snapshot the sample now; later writes cannot touch this frame.
                    shift_next   = load_word;
                    bit_cnt_next = '0;
                    wrap_next    = 1'b0;
                    state_next   = SHIFT;
                end
            end

            SHIFT: begin
                if (sclk_rise) begin
                    // Address bits arrive on rising edges 3..(2+ADDR_W), MSB first.
                    for (int i = 0; i < ADDR_W; i++)
                        if (bit_cnt_reg == 4'(2 + i))
                            next_addr_next[ADDR_W-1-i] = din_s;
                    if (bit_cnt_reg == 4'd15) begin
                        bit_cnt_next  = '0;
                        cur_addr_next = next_addr_reg;
                        done_next     = 1'b1;
                        wrap_next     = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end

                if (cs_rise) begin
                    state_next   = IDLE;
                    shift_next   = '0;
                    bit_cnt_next = '0;
                    wrap_next    = 1'b0;
                    // A CS rise in the same Clk as the 16th rising edge completes
                    // the frame (handled above); anything else mid-frame is an abort.
                    if (bit_cnt_reg != 4'd0 && !(sclk_rise && bit_cnt_reg == 4'd15))
                        err_next = 1'b1;
                end else if (sclk_fall) begin
                    if (wrap_reg) begin
                        // Continuous mode: next frame starts from the new address.
                        shift_next = load_word;
                        wrap_next  = 1'b0;
                    end else begin
                        shift_next = {shift_reg[FRAME_W-2:0], 1'b0};
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.Spi_dout   = shift_reg[FRAME_W-1];
    assign bus.Frame_done = done_reg;
    assign bus.Frame_err  = err_reg;
    assign bus.Cur_addr   = cur_addr_reg;
endmodule
